// File: rtl/lcd_refresh_ctrl_if.sv
// rtl/lcd_refresh_ctrl_if.sv - frame RAM read port and ST7565 SPI pins of the refresh engine
interface lcd_refresh_ctrl_if;
  logic [9:0] addr_r;
  logic [7:0] data_r;
  logic       lcd_cs_n;
  logic       lcd_sclk;
  logic       lcd_mosi;
  logic       lcd_dc;
  logic       lcd_rst_n;

  modport master (
    output addr_r,
    input  data_r,
    output lcd_cs_n,
    output lcd_sclk,
    output lcd_mosi,
    output lcd_dc,
    output lcd_rst_n
  );

  modport slave (
    input  addr_r,
    output data_r,
    input  lcd_cs_n,
    input  lcd_sclk,
    input  lcd_mosi,
    input  lcd_dc,
    input  lcd_rst_n
  );
endinterface

// File: rtl/lcd_refresh_ctrl.sv
// rtl/lcd_refresh_ctrl.sv - scans the 1024x8 frame RAM and streams it to an ST7565 LCD over SPI
// Optional power-up reset/init sequence enabled by defining LCD_INIT_SEQ_EN.
module lcd_refresh_ctrl #(
  parameter int         CLK_DIV    = 4,
  parameter logic [7:0] COL_OFFSET = 8'd0,
  parameter int         RST_CYCLES = 1000
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic               auto_en,
  output logic               busy,
  output logic               frame_done,
  lcd_refresh_ctrl_if.master lcd
);
  localparam int            DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    DONE
`ifdef LCD_INIT_SEQ_EN
    , INIT
`endif
  } state_t;

  state_t        state;
  logic [2:0]    page;
  logic [6:0]    col;
  logic [3:0]    idx;
  logic [7:0]    sh;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic          shifting;
  logic [3:0]    idx_nx;
  logic [2:0]    page_nx;

  function automatic logic [9:0] ram_addr(input logic [2:0] p, input logic [6:0] c);
    return {p[2:1], c, p[0]};
  endfunction

  function automatic logic [7:0] cmd_byte(input logic [3:0] i, input logic [2:0] p);
    case (i)
      4'd0:    cmd_byte = {5'b10110, p};
      4'd1:    cmd_byte = {4'h1, COL_OFFSET[7:4]};
      default: cmd_byte = {4'h0, COL_OFFSET[3:0]};
    endcase
  endfunction

`ifdef LCD_INIT_SEQ_EN
  localparam int RW = $clog2(RST_CYCLES + 1);
  logic [1:0]    init_ph;
  logic [RW-1:0] cnt;

  function automatic logic [7:0] init_byte(input logic [3:0] i);
    case (i)
      4'd0:    init_byte = 8'hA2;
      4'd1:    init_byte = 8'hA0;
      4'd2:    init_byte = 8'hC8;
      4'd3:    init_byte = 8'h2F;
      4'd4:    init_byte = 8'h27;
      4'd5:    init_byte = 8'h81;
      4'd6:    init_byte = 8'h10;
      4'd7:    init_byte = 8'h40;
      default: init_byte = 8'hAF;
    endcase
  endfunction
`else
  assign lcd.lcd_rst_n = 1'b1;
`endif

  always_comb begin
    shifting = (state == CMD) || (state == DATA);
`ifdef LCD_INIT_SEQ_EN
    if (state == INIT && init_ph == 2'd2) shifting = 1'b1;
`endif
    idx_nx  = idx + 4'd1;
    page_nx = page + 3'd1;
  end

  // MSB of the shifter is the line; clearing the shifter parks mosi low
  assign lcd.lcd_mosi = sh[7];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
`ifdef LCD_INIT_SEQ_EN
      state         <= INIT;
      init_ph       <= 2'd0;
      cnt           <= '0;
      lcd.lcd_rst_n <= 1'b0;
`else
      state         <= IDLE;
`endif
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      lcd.addr_r   <= '0;
      lcd.lcd_cs_n <= 1'b1;
      lcd.lcd_sclk <= 1'b0;
      lcd.lcd_dc   <= 1'b0;
      sh           <= '0;
      page         <= '0;
      col          <= '0;
      idx          <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
    end else begin
      frame_done <= 1'b0;
      if (shifting) begin
        if (div_cnt != DIV_LAST) begin
          div_cnt <= div_cnt + DW'(1);
        end else begin
          div_cnt      <= '0;
          lcd.lcd_sclk <= ~lcd.lcd_sclk;
          if (lcd.lcd_sclk && bit_cnt != 3'd7) begin
            bit_cnt <= bit_cnt + 3'd1;
            sh      <= {sh[6:0], 1'b0};
          end else if (lcd.lcd_sclk) begin
            // Byte boundary: next byte goes out with no gap; data_r answers the address set one byte earlier
            bit_cnt <= '0;
            case (state)
              CMD: begin
                if (idx == 4'd2) begin
                  state      <= DATA;
                  idx        <= '0;
                  sh         <= lcd.data_r;
                  lcd.lcd_dc <= 1'b1;
                  lcd.addr_r <= ram_addr(page, 7'd1);
                end else begin
                  idx <= idx_nx;
                  sh  <= cmd_byte(idx_nx, page);
                end
              end
              DATA: begin
                if (col == 7'd127) begin
                  col        <= '0;
                  idx        <= '0;
                  lcd.lcd_dc <= 1'b0;
                  if (page == 3'd7) begin
                    state        <= DONE;
                    busy         <= 1'b0;
                    frame_done   <= 1'b1;
                    lcd.lcd_cs_n <= 1'b1;
                    sh           <= '0;
                    page         <= '0;
                    lcd.addr_r   <= '0;
                  end else begin
                    state      <= CMD;
                    page       <= page_nx;
                    sh         <= cmd_byte(4'd0, page_nx);
                    lcd.addr_r <= ram_addr(page_nx, 7'd0);
                  end
                end else begin
                  col        <= col + 7'd1;
                  sh         <= lcd.data_r;
                  lcd.addr_r <= ram_addr(page, col + 7'd2);
                end
              end
`ifdef LCD_INIT_SEQ_EN
              INIT: begin
                if (idx == 4'd8) begin
                  state        <= IDLE;
                  busy         <= 1'b0;
                  lcd.lcd_cs_n <= 1'b1;
                  sh           <= '0;
                  idx          <= '0;
                end else begin
                  idx <= idx_nx;
                  sh  <= init_byte(idx_nx);
                end
              end
`endif
              default: ;
            endcase
          end
        end
      end

      case (state)
        IDLE, DONE: begin
          if ((state == IDLE) ? start : auto_en) begin
            state        <= CMD;
            busy         <= 1'b1;
            lcd.lcd_cs_n <= 1'b0;
            lcd.lcd_dc   <= 1'b0;
            lcd.lcd_sclk <= 1'b0;
            lcd.addr_r   <= '0;
            sh           <= cmd_byte(4'd0, 3'd0);
            page         <= '0;
            col          <= '0;
            idx          <= '0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
          end else begin
            state <= IDLE;
          end
        end
`ifdef LCD_INIT_SEQ_EN
        INIT: begin
          case (init_ph)
            2'd0: begin
              busy <= 1'b1;
              if (cnt == RW'(RST_CYCLES)) begin
                lcd.lcd_rst_n <= 1'b1;
                cnt           <= '0;
                init_ph       <= 2'd1;
              end else begin
                cnt <= cnt + RW'(1);
              end
            end
            2'd1: begin
              busy <= 1'b1;
              if (cnt == RW'(RST_CYCLES - 1)) begin
                init_ph      <= 2'd2;
                lcd.lcd_cs_n <= 1'b0;
                lcd.lcd_dc   <= 1'b0;
                lcd.lcd_sclk <= 1'b0;
                sh           <= init_byte(4'd0);
                idx          <= '0;
                div_cnt      <= '0;
                bit_cnt      <= '0;
              end else begin
                cnt <= cnt + RW'(1);
              end
            end
            default: ;
          endcase
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// tb/tb_lcd_refresh_ctrl.sv - directed bench for lcd_refresh_ctrl (honours LCD_INIT_SEQ_EN)
module tb_lcd_refresh_ctrl;
  localparam int CD      = 2;
  localparam int FRAME_Q = 1048;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic sys_rst;
  logic start0, start1, auto_en0, auto_en1;
  logic busy0, busy1, frame_done0, frame_done1;

  lcd_refresh_ctrl_if bus0 ();
  lcd_refresh_ctrl_if bus1 ();

  lcd_refresh_ctrl #(.CLK_DIV(CD), .COL_OFFSET(8'h00), .RST_CYCLES(20)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start0), .auto_en(auto_en0),
    .busy(busy0), .frame_done(frame_done0), .lcd(bus0));

  lcd_refresh_ctrl #(.CLK_DIV(CD), .COL_OFFSET(8'h04), .RST_CYCLES(20)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start1), .auto_en(auto_en1),
    .busy(busy1), .frame_done(frame_done1), .lcd(bus1));

  function automatic logic [7:0] ram_val(input logic [9:0] a);
    return a[7:0] ^ {6'd0, a[9:8]};
  endfunction

  always @(posedge sys_clk) begin
    bus0.data_r <= ram_val(bus0.addr_r);
    bus1.data_r <= ram_val(bus1.addr_r);
  end

  // SPI decoder: one {dc, byte} entry per 8 rising sclk edges inside a cs_n window
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int         bc[2];
  logic [7:0] sr[2];
  logic       ps[2];
  int         fd_cnt = 0;

  task automatic dec_step(input int k, input logic cs, input logic sc, input logic mo, input logic dcv);
    if (cs) begin
      bc[k] = 0;
    end else if (sc && !ps[k]) begin
      sr[k] = {sr[k][6:0], mo};
      bc[k] = bc[k] + 1;
      if (bc[k] == 8) begin
        bc[k] = 0;
        if (k == 0) q0.push_back({dcv, sr[k]});
        else        q1.push_back({dcv, sr[k]});
      end
    end
    ps[k] = sc;
  endtask

  always @(negedge sys_clk) begin
    dec_step(0, bus0.lcd_cs_n, bus0.lcd_sclk, bus0.lcd_mosi, bus0.lcd_dc);
    dec_step(1, bus1.lcd_cs_n, bus1.lcd_sclk, bus1.lcd_mosi, bus1.lcd_dc);
    if (frame_done0) fd_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] exp_byte(input int i, input logic [7:0] off);
    int         p = i / 131;
    int         r = i % 131;
    logic [2:0] pp = p[2:0];
    logic [6:0] c = 7'(r - 3);
    if (r == 0) return {1'b0, 5'b10110, pp};
    if (r == 1) return {1'b0, 4'h1, off[7:4]};
    if (r == 2) return {1'b0, 4'h0, off[3:0]};
    return {1'b1, ram_val({pp[2:1], c, pp[0]})};
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_frame_done"}, frame_done0, 0);
    chk({tag, "_addr_r"}, bus0.addr_r, 0);
    chk({tag, "_cs_n"}, bus0.lcd_cs_n, 1);
    chk({tag, "_sclk"}, bus0.lcd_sclk, 0);
    chk({tag, "_mosi"}, bus0.lcd_mosi, 0);
    chk({tag, "_dc"}, bus0.lcd_dc, 0);
`ifdef LCD_INIT_SEQ_EN
    chk({tag, "_rst_n"}, bus0.lcd_rst_n, 0);
`else
    chk({tag, "_rst_n"}, bus0.lcd_rst_n, 1);
`endif
  endtask

  task automatic wait_q0(input int n, input int limit);
    int c = 0;
    while (q0.size() < n && c < limit) begin
      @(negedge sys_clk);
      c++;
    end
    chk("wait_bytes", q0.size() >= n, 1);
  endtask

  // Counts cs_n-low samples until cs_n rises; pulses start once mid-frame
  task automatic run_frame(input int pulse_at, input int low0, output int low);
    int c = 0;
    low = low0;
    while (c < 40000) begin
      @(negedge sys_clk);
      c++;
      start0 = (c == pulse_at);
      if (bus0.lcd_cs_n) break;
      low++;
    end
    start0 = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    int bad = 0;
    chk({tag, "_byte_count"}, q0.size(), FRAME_Q);
    if (q0.size() >= FRAME_Q)
      for (int i = 0; i < FRAME_Q; i++)
        if (q0[i] !== exp_byte(i, 8'h00)) bad++;
    chk({tag, "_model_diffs"}, bad, 0);
  endtask

`ifdef LCD_INIT_SEQ_EN
  task automatic run_init();
    logic [7:0] init_exp[9] = '{8'hA2, 8'hA0, 8'hC8, 8'h2F, 8'h27, 8'h81, 8'h10, 8'h40, 8'hAF};
    int lo = 0;
    int c  = 0;
    int fd0 = fd_cnt;
    do begin
      @(negedge sys_clk);
      c++;
      if (!bus0.lcd_rst_n) lo++;
    end while (!bus0.lcd_rst_n && c < 500);
    chk("init_rst_low_cycles", lo, 20);
    c = 0;
    while (busy0 && c < 3000) begin
      @(negedge sys_clk);
      c++;
    end
    chk("init_busy_fall", busy0, 0);
    chk("init_byte_count", q0.size(), 9);
    if (q0.size() >= 9)
      for (int i = 0; i < 9; i++) chk($sformatf("init_byte%0d", i), q0[i], {1'b0, init_exp[i]});
    chk("init_no_frame_done", fd_cnt, fd0);
    q0.delete();
    q1.delete();
  endtask
`endif

  typedef struct {
    int         idx;
    logic       dc;
    logic [7:0] val;
  } vec_t;

  vec_t tbl[12];
  int   low;
  int   bad;
  logic [5:0] sc_pat, mo_pat;

  initial begin
    tbl[0]  = '{0,    1'b0, 8'hB0};
    tbl[1]  = '{1,    1'b0, 8'h10};
    tbl[2]  = '{2,    1'b0, 8'h00};
    tbl[3]  = '{3,    1'b1, 8'h00};
    tbl[4]  = '{4,    1'b1, 8'h02};
    tbl[5]  = '{130,  1'b1, 8'hFE};
    tbl[6]  = '{131,  1'b0, 8'hB1};
    tbl[7]  = '{134,  1'b1, 8'h01};
    tbl[8]  = '{397,  1'b1, 8'h02};
    tbl[9]  = '{524,  1'b0, 8'hB4};
    tbl[10] = '{668,  1'b1, 8'h17};
    tbl[11] = '{1047, 1'b1, 8'hFC};

    sys_rst = 1'b1; start0 = 1'b0; start1 = 1'b0; auto_en0 = 1'b1; auto_en1 = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_reset_vals("reset");

`ifdef LCD_INIT_SEQ_EN
    sys_rst = 1'b0;
    run_init();
    @(negedge sys_clk);
    start0 = 1'b1; start1 = 1'b1;
`else
    sys_rst = 1'b0; start0 = 1'b1; start1 = 1'b1;
`endif
    @(negedge sys_clk);
    start0 = 1'b0; start1 = 1'b0;
    chk("start_busy", busy0, 1);
    chk("start_cs_n", bus0.lcd_cs_n, 0);
    chk("start_dc", bus0.lcd_dc, 0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge sys_clk);
      sc_pat[i] = bus0.lcd_sclk;
      mo_pat[i] = bus0.lcd_mosi;
    end
    chk("sclk_phase_pattern", sc_pat, 6'b001100);
    chk("mosi_first_bits", mo_pat, 6'b001111);

    run_frame(500, 6, low);
    chk("frame1_cs_low_cycles", low, FRAME_Q * 16 * CD);
    chk("frame1_done_pulse", frame_done0, 1);
    chk("frame1_done_busy", busy0, 0);
    @(negedge sys_clk);
    chk("auto_cs_low_again", bus0.lcd_cs_n, 0);
    chk("auto_busy", busy0, 1);
    chk("auto_done_cleared", frame_done0, 0);
    auto_en0 = 1'b0;

    check_frame("frame1");
    if (q0.size() >= FRAME_Q)
      for (int i = 0; i < 12; i++)
        chk($sformatf("tbl_byte%0d", tbl[i].idx), q0[tbl[i].idx], {tbl[i].dc, tbl[i].val});

    chk("off4_byte_count", q1.size(), FRAME_Q);
    if (q1.size() >= FRAME_Q) begin
      chk("off4_b0", q1[0], 9'h0B0);
      chk("off4_b1", q1[1], 9'h010);
      chk("off4_b2", q1[2], 9'h004);
      chk("off4_p1_b0", q1[131], 9'h0B1);
      chk("off4_p1_b2", q1[133], 9'h004);
    end

    // Abort the auto-started frame mid-byte in page 3
    wait_q0(FRAME_Q + 3 * 131 + 10, 20000);
    repeat (3) @(negedge sys_clk);
    chk("page3_addr_hi", bus0.addr_r[9:8], 2'b01);
    chk("page3_addr_lsb", bus0.addr_r[0], 1'b1);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk_reset_vals("midframe_reset");
    q0.delete();

`ifdef LCD_INIT_SEQ_EN
    sys_rst = 1'b0;
    run_init();
    @(negedge sys_clk);
    start0 = 1'b1;
`else
    sys_rst = 1'b0; start0 = 1'b1;
`endif
    @(negedge sys_clk);
    start0 = 1'b0;
    chk("restart_cs_n", bus0.lcd_cs_n, 0);
    run_frame(2000, 1, low);
    chk("frame3_cs_low_cycles", low, FRAME_Q * 16 * CD);
    chk("frame3_done_pulse", frame_done0, 1);
    check_frame("frame3");

    bad = 0;
    repeat (40) begin
      @(negedge sys_clk);
      if (busy0 || !bus0.lcd_cs_n || frame_done0) bad++;
    end
    chk("idle_after_frame", bad, 0);
    chk("frame_done_count", fd_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
